// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer for a 4:1 data mux: one owner at a time holds the
// downstream valid/ready channel for a whole packet (in_last or MAX_BEATS beats).
module rr_mux_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_last,
  output logic [3:0]          gnt,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [1:0]          sel,
  output logic                busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q;
  logic [1:0] sel_q, sel_d, ptr_q, idx;
  logic [7:0] beat_cnt_q;
  logic       owned, at_limit, xfer;

  // Scan ptr+4 down to ptr+1 so the nearest set bit after ptr is written last.
  always_comb begin
    sel_d = ptr_q;
    idx   = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) sel_d = idx;
    end
  end

  assign owned     = (state_q == GRANT);
  assign at_limit  = (beat_cnt_q == 8'(MAX_BEATS - 1));
  assign out_valid = owned & req[sel_q];
  assign out_data  = owned ? in_data[32'(sel_q)*DATA_W +: DATA_W] : '0;
  assign out_last  = out_valid & (in_last[sel_q] | at_limit);
  assign xfer      = out_valid & out_ready;
  assign sel       = sel_q;
  assign busy      = owned;

  for (genvar i = 0; i < 4; i++) begin : g_gnt
    assign gnt[i] = owned & (sel_q == 2'(i)) & out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd3;
      beat_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          sel_q      <= sel_d;
          beat_cnt_q <= 8'd0;
          state_q    <= GRANT;
        end
        GRANT: if (xfer) begin
          if (out_last) begin
            ptr_q      <= sel_q;
            beat_cnt_q <= 8'd0;
            state_q    <= IDLE;
          end else begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed packet scenarios plus randomized traffic,
// every cycle compared against a packet-level ownership model.
module tb_rr_mux_arbiter;
  localparam int DW = 8;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]    in_last = '0;
  logic [3:0]    gnt;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic [1:0]    sel;
  logic          busy;

  rr_mux_arbiter #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data), .in_last(in_last),
    .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int d_chk = 0, d_pass = 0, m_chk = 0, m_pass = 0;

  // model state: owner -1 means no owner
  int m_owner = -1, m_ptr = 3, m_sel = 0, m_cnt = 0;
  // DUT observations for directed checks
  int grants[$];
  int xfer_n = 0, last_at = -1;
  logic busy_prev = 1'b0;

  task automatic mchk(string nm, logic [31:0] a, logic [31:0] e);
    m_chk++;
    if (a === e) m_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, a, e);
  endtask

  task automatic dchk(string nm, logic [31:0] a, logic [31:0] e);
    d_chk++;
    if (a === e) d_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, a, e);
  endtask

  // compare + model step on every falling edge (inputs are stable here)
  always @(negedge clk) begin
    logic [3:0] eg;
    logic       ev, el;
    logic [DW-1:0] ed;
    if (rst) begin
      m_owner = -1; m_ptr = 3; m_sel = 0; m_cnt = 0;
      mchk("rst_out", {gnt, out_valid, out_data, out_last, sel, busy}, '0);
      busy_prev = 1'b0;
    end else begin
      if (m_owner < 0) begin
        eg = '0; ev = 1'b0; ed = '0; el = 1'b0;
      end else begin
        ev = req[m_owner];
        ed = in_data[m_owner*DW +: DW];
        eg = out_ready ? 4'(1 << m_owner) : 4'h0;
        el = ev & (in_last[m_owner] | (m_cnt == MB - 1));
      end
      mchk("gnt", 32'(gnt), 32'(eg));
      mchk("out_valid", 32'(out_valid), 32'(ev));
      mchk("out_data", 32'(out_data), 32'(ed));
      mchk("out_last", 32'(out_last), 32'(el));
      mchk("sel", 32'(sel), 32'(m_sel));
      mchk("busy", 32'(busy), 32'(m_owner >= 0));
      // DUT observations
      if (busy && !busy_prev) grants.push_back(int'(sel));
      busy_prev = busy;
      if (out_valid && out_ready) begin
        xfer_n++;
        if (out_last) last_at = xfer_n;
      end
      // model step for the coming rising edge
      if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (m_ptr + k) % 4;
          if (m_owner < 0 && req[j]) m_owner = j;
        end
        if (m_owner >= 0) begin m_sel = m_owner; m_cnt = 0; end
      end else if (ev && out_ready) begin
        if (el) begin m_ptr = m_owner; m_owner = -1; m_cnt = 0; end
        else m_cnt++;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; in_last = '0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int x0, g0, k;
    #3;
    dchk("reset_state", {gnt, out_valid, out_data, out_last, sel, busy}, '0);
    out_ready = 1'b1;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step(2);
    rst = 1'b0;

    // T1: single requester, 3-beat packet
    req = 4'b0001;
    x0 = xfer_n;
    step(1);
    dchk("t1_busy", 32'(busy), 1);
    dchk("t1_gnt", 32'(gnt), 32'h1);
    step(2);
    in_last = 4'b0001;
    #1 dchk("t1_last", 32'(out_last), 1);
    step(1);
    dchk("t1_released", 32'(busy), 0);
    dchk("t1_xfers", 32'(xfer_n - x0), 3);
    req = 4'b0011; in_last = 4'b1111;
    step(1);
    dchk("t1_ptr0_next1", 32'(sel), 1);
    step(1);
    req = '0;

    // T2: fairness with 1-beat packets
    do_reset();
    req = 4'b1111; in_last = 4'b1111;
    g0 = grants.size();
    step(10);
    dchk("t2_ngrants", 32'(grants.size() - g0 >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (grants.size() > g0 + i) dchk("t2_order", 32'(grants[g0+i]), 32'(i % 4));

    // T3: beat-limit forced release
    do_reset();
    req = 4'b0100; in_last = '0;
    step(1);
    dchk("t3_sel2", 32'(sel), 2);
    req = 4'b0110;
    x0 = xfer_n;
    k = 0;
    while (busy && k < 40) begin step(1); k++; end
    dchk("t3_released", 32'(busy), 0);
    dchk("t3_beats", 32'(xfer_n - x0), MB);
    dchk("t3_last_at", 32'(last_at - x0), MB);
    k = 0;
    while (!busy && k < 5) begin step(1); k++; end
    dchk("t3_next_owner1", 32'(sel), 1);

    // T4: owner drops req mid-packet
    do_reset();
    req = 4'b0010; in_last = '0;
    step(1);
    step(2);
    req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1;
      dchk("t4_hold", {out_valid, sel, busy}, {1'b0, 2'd1, 1'b1});
      step(1);
    end
    req = 4'b1010; in_last = 4'b0010;
    step(1);
    dchk("t4_released", 32'(busy), 0);
    req = 4'b1000; in_last = '0;
    step(1);
    dchk("t4_owner3", {sel, busy}, {2'd3, 1'b1});

    // T5: backpressure
    do_reset();
    in_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    req = 4'b0001; in_last = '0; out_ready = 1'b1;
    step(1);
    x0 = xfer_n;
    step(1);
    out_ready = 1'b0;
    #1 dchk("t5_stall", {gnt, out_valid, out_data}, {4'h0, 1'b1, 8'hA5});
    step(1);
    dchk("t5_hold_cnt", 32'(xfer_n - x0), 1);
    dchk("t5_hold_data", 32'(out_data), 32'hA5);
    step(1);
    out_ready = 1'b1;
    step(1);
    dchk("t5_xfers", 32'(xfer_n - x0), 2);

    // T6: reset mid-packet
    do_reset();
    req = 4'b0100; in_last = '0;
    step(2);
    rst = 1'b1;
    #1 dchk("t6_async", {gnt, out_valid, out_data, out_last, sel, busy}, '0);
    step(2);
    rst = 1'b0; req = 4'b1111; in_last = 4'b1111;
    step(1);
    dchk("t6_first0", {sel, busy}, {2'd0, 1'b1});

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step(1);
      rst = ($urandom_range(0, 299) == 0);
      req = 4'($urandom);
      in_last = 4'($urandom) & 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = 32'($urandom);
    end
    step(2);

    $display("%0d/%0d checks passed", d_pass + m_pass, d_chk + m_chk);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4:1 data multiplexer.
- Shares one downstream valid/ready channel among four requesters and drives the mux select.
- Holds a grant for a whole packet: until in_last, or until MAX_BEATS beats, whichever comes first.
- Sits between four producer ports and a single consumer; the select register is the only control path into the mux.

Parameters:
- DATA_W, 8, width of each requester data word and of out_data.
- MAX_BEATS, 16, maximum beats per grant before forced release (valid range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  4  per-requester valid; bit i = requester i has a beat.
- in_data  in  4*DATA_W  requester data; slice i at [i*DATA_W +: DATA_W].
- in_last  in  4  per-requester end-of-packet flag.
- gnt  out  4  per-requester ready, one-hot or zero.
- out_valid  out  1  downstream valid.
- out_data  out  DATA_W  downstream data, the selected slice.
- out_last  out  1  downstream end-of-grant marker.
- out_ready  in  1  downstream ready.
- sel  out  2  registered mux select / current owner index.
- busy  out  1  high while in state GRANT.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE, sel=0, ptr=3, beat_cnt=0.
  - gnt=0, out_valid=0, out_data=0, out_last=0, busy=0.
  - With ptr=3, requester 0 wins the first arbitration.
- States:
  - IDLE: no owner.
  - GRANT: sel owns the channel.
- IDLE to GRANT:
  - If req != 0, pick the first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Register the winner into sel, clear beat_cnt, enter GRANT next cycle.
  - Arbitration latency: 1 cycle from req rising to busy=1.
  - No beat transfers in IDLE; all outputs are 0.
- Outputs in GRANT (combinational from sel):
  - out_valid = req[sel].
  - out_data = in_data[sel].
  - gnt[sel] = out_ready; other gnt bits = 0.
  - out_last = req[sel] & (in_last[sel] | beat_cnt == MAX_BEATS-1).
- Transfer: a beat transfers on a cycle with out_valid & out_ready.
  - Each transfer increments beat_cnt (8-bit, never wraps because of release below).
- Release: on a transfer with out_last=1:
  - ptr <= sel, beat_cnt <= 0, state <= IDLE.
  - Earliest re-arbitration is the following cycle; the minimum gap between grants is 1 idle cycle.
- Owner deasserts req mid-packet: grant is kept (locked), out_valid=0, no timeout. Other requesters wait.
- Non-owner req changes during GRANT: ignored, with no effect on sel.
- out_ready low: beat holds, beat_cnt holds, no state change.
- MAX_BEATS=1: every transfer releases; degenerates to per-beat round-robin.
- Simultaneous last and beat limit: a single release, no double update.
- Fairness: under continuous requests from all four, grants rotate 0,1,2,3,0…
- Reset mid-packet: immediate return to the reset values; the partial packet is abandoned and the bench must not expect completion.
- sel keeps its value in IDLE after release; it is not cleared.

Test Plan:
- Reset then req=4'b0001, in_last=1 on 3rd beat, out_ready=1 -> busy=1 one cycle after req; three transfers with gnt=4'b0001; out_last on beat 3; busy=0; ptr=0.
- req=4'b1111 held, every packet 1 beat (in_last=1) -> grant order sel=0,1,2,3,0 with one IDLE cycle between grants.
- MAX_BEATS=16, requester 2 streaming with in_last=0 and req=4'b0110 -> forced out_last on beat 16; requester 1 is granted next, not requester 2.
- Owner 1 drops req for 5 cycles mid-packet while req[3]=1 -> out_valid=0 and sel stays 1 throughout; resume completes the packet; only then is requester 3 granted.
- out_ready toggling 1,0,0,1 during a grant -> transfers only on ready cycles; beat_cnt and out_data stable while ready=0.
- Assert rst on beat 2 of a 4-beat packet -> all outputs 0 asynchronously; after release, requester 0 has first priority again.
